seq_core_mc: RTL and testbench



---
 rtl/seq_core_mc.sv | 156 +++++++++++++++
 tb/tb_seq_core_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_core_mc.sv
// seq_core_mc: multi-cycle 16-bit-ISA core with RUN/MEM/HALT FSM and mem_ready-handshaked LOAD/STORE.
// Optional shift opcodes are enabled by defining SEQ_CORE_SHIFT_EN; without it they decode as NOP.
module seq_core_mc #(
    parameter int A_SIZE = 10,
    parameter int D_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [A_SIZE-1:0] pc,
    input  logic [15:0]       instruction,
    output logic              read,
    output logic              write,
    output logic [A_SIZE-1:0] address,
    input  logic [D_SIZE-1:0] data_in,
    output logic [D_SIZE-1:0] data_out,
    input  logic              mem_ready,
    output logic              halted
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_MEM = 2'd1, S_HALT = 2'd2} state_t;
    state_t            r_state;
    state_t            w_next;
    logic [D_SIZE-1:0] r_regs [8];
    logic [A_SIZE-1:0] r_pc;
    logic [A_SIZE-1:0] r_address;
    logic [D_SIZE-1:0] r_data_out;
    logic              r_read;
    logic              r_write;
    logic [2:0]        r_ld_dst;
    logic [6:0]        w_op7;
    logic [4:0]        w_op5;
    logic [3:0]        w_op4;
    logic [D_SIZE-1:0] w_a;
    logic [D_SIZE-1:0] w_b;
    logic [D_SIZE-1:0] w_c;
    logic [D_SIZE-1:0] w_hi;
    logic [A_SIZE-1:0] w_rel;
    logic              w_taken;
    logic [A_SIZE-1:0] w_pc_next;
    logic              w_wr_en;
    logic [2:0]        w_wr_dst;
    logic [D_SIZE-1:0] w_wr_val;
    logic              w_load;
    logic              w_store;
    logic              w_halt;
    assign w_op7   = instruction[15:9];
    assign w_op5   = instruction[15:11];
    assign w_op4   = instruction[15:12];
    assign w_a     = r_regs[instruction[5:3]];
    assign w_b     = r_regs[instruction[2:0]];
    assign w_c     = r_regs[instruction[8:6]];
    assign w_hi    = r_regs[instruction[10:8]];
    assign w_rel   = A_SIZE'($signed(instruction[5:0]));
    assign w_taken = instruction[11] ? 1'b0 :
                     instruction[10] ? (instruction[9] ? |w_c : ~|w_c) :
                                       (instruction[9] ? ~w_c[D_SIZE-1] : w_c[D_SIZE-1]);
    assign pc       = r_pc;
    assign read     = r_read;
    assign write    = r_write;
    assign address  = r_address;
    assign data_out = r_data_out;
    assign halted   = (r_state == S_HALT);
    // Decode the current instruction into next pc, register write-back and memory-request intent.
    always_comb begin
        w_pc_next = r_pc + 1'b1;
        w_wr_en   = 1'b0;
        w_wr_dst  = instruction[8:6];
        w_wr_val  = '0;
        w_load    = 1'b0;
        w_store   = 1'b0;
        w_halt    = 1'b0;
        if (instruction == 16'hFFFF) begin
            w_halt    = 1'b1;
            w_pc_next = r_pc;
        end else if (w_op4 == 4'b1000) begin
            w_pc_next = w_b[A_SIZE-1:0];
        end else if (w_op4 == 4'b1001) begin
            w_pc_next = r_pc + w_rel;
        end else if (w_op4 == 4'b1010) begin
            w_pc_next = w_taken ? w_b[A_SIZE-1:0] : r_pc + 1'b1;
        end else if (w_op4 == 4'b1011) begin
            w_pc_next = w_taken ? r_pc + w_rel : r_pc + 1'b1;
        end else if (w_op5 == 5'b00101) begin
            w_wr_en  = 1'b1;
            w_wr_dst = instruction[10:8];
            w_wr_val = D_SIZE'(instruction[7:0]);
        end else if (w_op5 == 5'b00100) begin
            w_load    = 1'b1;
            w_pc_next = r_pc;
        end else if (w_op5 == 5'b00110) begin
            w_store   = 1'b1;
            w_pc_next = r_pc;
        end else begin
            w_wr_en = 1'b1;
            case (w_op7)
                7'b0000001: w_wr_val = w_a + w_b;
                7'b0000011: w_wr_val = w_a - w_b;
                7'b0000101: w_wr_val = w_a & w_b;
                7'b0000110: w_wr_val = w_a | w_b;
                7'b0000111: w_wr_val = w_a ^ w_b;
                7'b0001000: w_wr_val = ~(w_a & w_b);
                7'b0001001: w_wr_val = ~(w_a | w_b);
                7'b0001010: w_wr_val = ~(w_a ^ w_b);
`ifdef SEQ_CORE_SHIFT_EN
                7'b0001011: w_wr_val = w_c >> instruction[5:0];
                7'b0001100: w_wr_val = $signed(w_c) >>> instruction[5:0];
                7'b0001101: w_wr_val = w_c << instruction[5:0];
`endif
                default:    w_wr_en = 1'b0;
            endcase
        end
    end
    // Next FSM state: RUN dispatches, MEM waits for mem_ready, HALT holds until reset.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   w_next = w_halt ? S_HALT : (w_load | w_store) ? S_MEM : S_RUN;
            S_MEM:   w_next = mem_ready ? S_RUN : S_MEM;
            default: w_next = S_HALT;
        endcase
    end
    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_RUN;
        else      r_state <= w_next;
    end
    // Datapath: register file, pc and memory-request registers; reset aborts any pending access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_pc       <= '0;
            r_address  <= '0;
            r_data_out <= '0;
            r_read     <= 1'b0;
            r_write    <= 1'b0;
            r_ld_dst   <= '0;
        end else if (r_state == S_RUN) begin
            r_pc <= w_pc_next;
            if (w_wr_en) r_regs[w_wr_dst] <= w_wr_val;
            if (w_load) begin
                r_address <= w_b[A_SIZE-1:0];
                r_read    <= 1'b1;
                r_ld_dst  <= instruction[10:8];
            end
            if (w_store) begin
                r_address  <= w_hi[A_SIZE-1:0];
                r_data_out <= w_b;
                r_write    <= 1'b1;
            end
        end else if (r_state == S_MEM && mem_ready) begin
            if (r_read) r_regs[r_ld_dst] <= data_in;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_pc    <= r_pc + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_core_mc.sv
// tb_seq_core_mc: directed vector table plus randomized run against a behavioural model of seq_core_mc.
module tb_seq_core_mc;
    localparam int A = 10;
    localparam int D = 32;
    localparam int AMOD = 1 << A;
`ifdef SEQ_CORE_SHIFT_EN
    localparam logic [31:0] SRA_EXP = 32'hF8000000;
`else
    localparam logic [31:0] SRA_EXP = 32'h80000000;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [A-1:0] pc;
    logic [15:0]  instruction = 16'h0000;
    logic         read;
    logic         write;
    logic [A-1:0] address;
    logic [D-1:0] data_in = '0;
    logic [D-1:0] data_out;
    logic         mem_ready = 1'b0;
    logic         halted;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_core_mc #(.A_SIZE(A), .D_SIZE(D)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instruction), .read(read), .write(write),
        .address(address), .data_in(data_in), .data_out(data_out), .mem_ready(mem_ready), .halted(halted)
    );

    typedef struct {
        logic [15:0] ins;
        logic        rdy;
        logic [31:0] din;
        logic        rn;
        int          pc;
        logic        rd;
        logic        wr;
        int          addr;
        logic [31:0] dout;
        logic        h;
    } vec_t;
    vec_t tbl[$];

    // behavioural model state: mode 0 = executing, 1 = waiting on memory, 2 = halted
    int          m_pc, m_addr, m_mode, m_dst;
    logic        m_read, m_write;
    logic [31:0] m_dout;
    logic [31:0] m_r[8];

    function automatic logic [15:0] f_alu(input logic [6:0] op, input int d, input int a, input int b);
        return {op, 3'(d), 3'(a), 3'(b)};
    endfunction
    function automatic logic [15:0] f_loadc(input int d, input int imm);
        return {5'b00101, 3'(d), 8'(imm)};
    endfunction
    function automatic logic [15:0] f_load(input int d, input int a);
        return {5'b00100, 3'(d), 5'b0, 3'(a)};
    endfunction
    function automatic logic [15:0] f_store(input int a, input int s);
        return {5'b00110, 3'(a), 5'b0, 3'(s)};
    endfunction
    function automatic logic [15:0] f_jc(input logic [3:0] op, input int cond, input int creg, input int low6);
        return {op, 3'(cond), 3'(creg), 6'(low6)};
    endfunction

    task automatic row(input logic [15:0] ins, input logic rdy, input logic [31:0] din, input logic rn,
                       input int epc, input logic erd, input logic ewr, input int ea,
                       input logic [31:0] ed, input logic eh);
        vec_t v;
        v = '{ins, rdy, din, rn, epc, erd, ewr, ea, ed, eh};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [15:0] ins, input logic rdy, input logic [31:0] din, input logic rn);
        instruction = ins;
        mem_ready   = rdy;
        data_in     = din;
        rst         = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input int epc, input logic erd, input logic ewr,
                         input int ea, input logic [31:0] ed, input logic eh);
        n_tests++;
        if (pc !== A'(epc) || read !== erd || write !== ewr || address !== A'(ea) || data_out !== ed || halted !== eh) begin
            n_fail++;
            $display("FAIL %s[%0d]: got pc=%0d rd=%b wr=%b addr=%0d dout=%h halted=%b, want pc=%0d rd=%b wr=%b addr=%0d dout=%h halted=%b",
                     nm, idx, pc, read, write, address, data_out, halted, epc, erd, ewr, ea, ed, eh);
        end
    endtask

    task automatic model_step(input logic [15:0] i, input logic rdy, input logic [31:0] din, input logic rn);
        logic [31:0] a, b, c, v;
        logic signed [31:0] sc;
        int off, amt, d;
        bit take;
        if (!rn) begin
            m_pc = 0; m_read = 0; m_write = 0; m_addr = 0; m_dout = 0; m_mode = 0;
            for (int r = 0; r < 8; r++) m_r[r] = 0;
        end else if (m_mode == 1) begin
            if (rdy) begin
                if (m_read) m_r[m_dst] = din;
                m_read = 0; m_write = 0; m_mode = 0;
                m_pc = (m_pc + 1) % AMOD;
            end
        end else if (m_mode == 0) begin
            a = m_r[i[5:3]]; b = m_r[i[2:0]]; c = m_r[i[8:6]];
            d = int'(i[8:6]);
            amt = int'(i[5:0]);
            off = (amt >= 32) ? amt - 64 : amt;
            case (i[11:9])
                3'd0: take = c[31];
                3'd1: take = !c[31];
                3'd2: take = (c == 0);
                3'd3: take = (c != 0);
                default: take = 0;
            endcase
            if (i == 16'hFFFF) m_mode = 2;
            else if (i[15:12] == 4'b1000) m_pc = int'(b[A-1:0]);
            else if (i[15:12] == 4'b1001) m_pc = (m_pc + off + AMOD) % AMOD;
            else if (i[15:12] == 4'b1010) m_pc = take ? int'(b[A-1:0]) : (m_pc + 1) % AMOD;
            else if (i[15:12] == 4'b1011) m_pc = take ? (m_pc + off + AMOD) % AMOD : (m_pc + 1) % AMOD;
            else if (i[15:11] == 5'b00101) begin
                m_r[i[10:8]] = 32'(i[7:0]);
                m_pc = (m_pc + 1) % AMOD;
            end else if (i[15:11] == 5'b00100) begin
                m_read = 1; m_addr = int'(b[A-1:0]); m_dst = int'(i[10:8]); m_mode = 1;
            end else if (i[15:11] == 5'b00110) begin
                v = m_r[i[10:8]];
                m_write = 1; m_addr = int'(v[A-1:0]); m_dout = b; m_mode = 1;
            end else begin
                case (i[15:9])
                    7'd1:  m_r[d] = a + b;
                    7'd3:  m_r[d] = a - b;
                    7'd5:  m_r[d] = a & b;
                    7'd6:  m_r[d] = a | b;
                    7'd7:  m_r[d] = a ^ b;
                    7'd8:  m_r[d] = ~(a & b);
                    7'd9:  m_r[d] = ~(a | b);
                    7'd10: m_r[d] = ~(a ^ b);
`ifdef SEQ_CORE_SHIFT_EN
                    7'd11: m_r[d] = (amt >= 32) ? 32'd0 : c / (33'd1 << amt);
                    7'd12: begin
                        if (amt >= 32) m_r[d] = c[31] ? 32'hFFFFFFFF : 32'd0;
                        else begin
                            sc = c;
                            sc = sc >>> amt;
                            m_r[d] = sc;
                        end
                    end
                    7'd13: m_r[d] = (amt >= 32) ? 32'd0 : c * (32'd1 << amt);
`endif
                    default: ;
                endcase
                m_pc = (m_pc + 1) % AMOD;
            end
        end
    endtask

    function automatic logic [15:0] gen();
        logic [6:0] ops[11] = '{7'd1, 7'd3, 7'd5, 7'd6, 7'd7, 7'd8, 7'd9, 7'd10, 7'd11, 7'd12, 7'd13};
        int s;
        s = $urandom_range(0, 15);
        case (s)
            0, 1, 2, 3: return f_loadc($urandom_range(0, 7), $urandom_range(0, 255));
            4, 5, 6:    return f_alu(ops[$urandom_range(0, 10)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            7:          return f_load($urandom_range(0, 7), $urandom_range(0, 7));
            8:          return f_store($urandom_range(0, 7), $urandom_range(0, 7));
            9:          return {4'b1000, 12'($urandom)};
            10:         return {4'b1001, 12'($urandom)};
            11:         return {4'b1010, 12'($urandom)};
            12:         return {4'b1011, 12'($urandom)};
            13:         return 16'h0000;
            14:         return 16'($urandom);
            default:    return ($urandom_range(0, 3) == 0) ? 16'hFFFF : f_loadc($urandom_range(0, 7), $urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [15:0] ins;
        logic rdy, rn;
        logic [31:0] din;
        int hcnt;
        // ALU basics
        row(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(f_loadc(0, 7), 0, 0, 1, 1, 0, 0, 0, 0, 0);
        row(f_loadc(1, 6), 0, 0, 1, 2, 0, 0, 0, 0, 0);
        row(f_alu(7'd1, 3, 0, 1), 0, 0, 1, 3, 0, 0, 0, 0, 0);
        row(f_alu(7'd3, 2, 0, 1), 0, 0, 1, 4, 0, 0, 0, 0, 0);
        row(f_alu(7'd8, 4, 0, 1), 0, 0, 1, 5, 0, 0, 0, 0, 0);
        row(f_store(0, 3), 1, 0, 1, 5, 0, 1, 7, 13, 0);
        row(16'h0000, 1, 0, 1, 6, 0, 0, 7, 13, 0);
        row(f_store(0, 2), 1, 0, 1, 6, 0, 1, 7, 1, 0);
        row(16'h0000, 1, 0, 1, 7, 0, 0, 7, 1, 0);
        row(f_store(0, 4), 1, 0, 1, 7, 0, 1, 7, 32'hFFFFFFF9, 0);
        row(16'h0000, 1, 0, 1, 8, 0, 0, 7, 32'hFFFFFFF9, 0);
        // STORE with mem_ready tied high
        row(f_loadc(2, 20), 1, 0, 1, 9, 0, 0, 7, 32'hFFFFFFF9, 0);
        row(f_store(0, 2), 1, 0, 1, 9, 0, 1, 7, 20, 0);
        row(16'h0000, 1, 0, 1, 10, 0, 0, 7, 20, 0);
        // LOAD with three not-ready MEM cycles
        row(f_loadc(5, 5), 0, 0, 1, 11, 0, 0, 7, 20, 0);
        row(f_load(6, 5), 1, 0, 1, 11, 1, 0, 5, 20, 0);
        row(16'h0000, 0, 32'h99, 1, 11, 1, 0, 5, 20, 0);
        row(16'h0000, 0, 32'h99, 1, 11, 1, 0, 5, 20, 0);
        row(16'h0000, 0, 32'h99, 1, 11, 1, 0, 5, 20, 0);
        row(16'h0000, 1, 5, 1, 12, 0, 0, 5, 20, 0);
        row(f_store(5, 6), 1, 0, 1, 12, 0, 1, 5, 5, 0);
        row(16'h0000, 1, 0, 1, 13, 0, 0, 5, 5, 0);
        // jumps
        row(f_loadc(5, 0), 0, 0, 1, 14, 0, 0, 5, 5, 0);
        row(f_loadc(4, 1), 0, 0, 1, 15, 0, 0, 5, 5, 0);
        row(f_jc(4'b1010, 2, 5, 4), 0, 0, 1, 1, 0, 0, 5, 5, 0);
        row(f_jc(4'b1010, 3, 5, 4), 0, 0, 1, 2, 0, 0, 5, 5, 0);
        row(f_jc(4'b1000, 0, 0, 5), 0, 0, 1, 0, 0, 0, 5, 5, 0);
        row(f_jc(4'b1001, 0, 0, -2), 0, 0, 1, AMOD - 2, 0, 0, 5, 5, 0);
        row(f_jc(4'b1011, 0, 4, 3), 0, 0, 1, AMOD - 1, 0, 0, 5, 5, 0);
        row(f_jc(4'b1011, 1, 4, 3), 0, 0, 1, 2, 0, 0, 5, 5, 0);
        row(f_jc(4'b1010, 4, 5, 4), 0, 0, 1, 3, 0, 0, 5, 5, 0);
        // SHIFTRA on 0x80000000
        row(f_load(0, 5), 1, 0, 1, 3, 1, 0, 0, 5, 0);
        row(16'h0000, 1, 32'h80000000, 1, 4, 0, 0, 0, 5, 0);
        row(f_alu(7'd12, 0, 0, 4), 0, 0, 1, 5, 0, 0, 0, 5, 0);
        row(f_store(5, 0), 1, 0, 1, 5, 0, 1, 0, SRA_EXP, 0);
        row(16'h0000, 1, 0, 1, 6, 0, 0, 0, SRA_EXP, 0);
        // HALT is absorbing
        row(16'hFFFF, 1, 0, 1, 6, 0, 0, 0, SRA_EXP, 1);
        for (int k = 0; k < 10; k++)
            row((k % 2) ? f_load(0, 5) : f_store(5, 0), 1, 32'h1234, 1, 6, 0, 0, 0, SRA_EXP, 1);
        // reset during a pending LOAD
        row(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        row(f_loadc(2, 8'h33), 0, 0, 1, 1, 0, 0, 0, 0, 0);
        row(f_load(2, 0), 0, 0, 1, 1, 1, 0, 0, 0, 0);
        row(16'h0000, 1, 32'hAB, 0, 0, 0, 0, 0, 0, 0);
        row(f_loadc(1, 8'h11), 0, 0, 1, 1, 0, 0, 0, 0, 0);
        row(f_store(0, 1), 1, 0, 1, 1, 0, 1, 0, 32'h11, 0);
        row(16'h0000, 1, 0, 1, 2, 0, 0, 0, 32'h11, 0);
        row(f_store(0, 2), 1, 32'hAB, 1, 2, 0, 1, 0, 0, 0);
        row(16'h0000, 1, 32'hAB, 1, 3, 0, 0, 0, 0, 0);

        drive(16'h0000, 0, 0, 0);
        foreach (tbl[k]) begin
            drive(tbl[k].ins, tbl[k].rdy, tbl[k].din, tbl[k].rn);
            check("vec", k, tbl[k].pc, tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].dout, tbl[k].h);
        end

        hcnt = 0;
        for (int k = 0; k < 3000; k++) begin
            ins = gen();
            rdy = ($urandom_range(0, 2) != 0);
            din = $urandom();
            rn  = !(k == 0 || hcnt >= 3 || $urandom_range(0, 99) == 0);
            model_step(ins, rdy, din, rn);
            drive(ins, rdy, din, rn);
            check("rand", k, m_pc, m_read, m_write, m_addr, m_dout, m_mode == 2);
            hcnt = (m_mode == 2) ? hcnt + 1 : 0;
        end

        if (m_mode == 2) begin
            model_step(16'h0000, 0, 0, 0);
            drive(16'h0000, 0, 0, 0);
            check("dump_rst", 0, m_pc, m_read, m_write, m_addr, m_dout, m_mode == 2);
        end
        for (int r = 0; r < 8; r++) begin
            model_step(f_store(0, r), 1, 0, 1);
            drive(f_store(0, r), 1, 0, 1);
            check("dump", r, m_pc, m_read, m_write, m_addr, m_dout, m_mode == 2);
            model_step(16'h0000, 1, 0, 1);
            drive(16'h0000, 1, 0, 1);
            check("dump_done", r, m_pc, m_read, m_write, m_addr, m_dout, m_mode == 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
